reg_scoreboard: RTL and testbench

- Tracks in-flight writes to the 32-entry general register file for the CPU pipeline.
- Decode presents an instruction's source registers (ra1/ra2) and destination register (wa). The scoreboard raises stall while a source register has an outstanding write.
- Writeback retires each write on the same cycle it drives the register file write port (we3/wa3).
- Retires become visible to readers in that cycle, matching the register file's negedge write.

---
 rtl/reg_scoreboard_if.sv | 29 ++
 rtl/reg_scoreboard.sv | 97 +++++++++
 tb/tb_reg_scoreboard.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// Decode / writeback / status bundle between the pipeline control and the register scoreboard.
interface reg_scoreboard_if;
    logic       issue_valid;
    logic       issue_we;
    logic [4:0] issue_wa;
    logic [4:0] ra1;
    logic [4:0] ra2;
    logic       wb_valid;
    logic [4:0] wb_wa;
    logic       flush;
    logic       stall;
    logic       busy1;
    logic       busy2;
    logic [7:0] pending_total;
    logic       err;

    // Decode offers an instruction with issue_valid; it issues in any cycle where stall is low
    // and flush is low. stall depends combinationally on issue_* and ra*; there is no registered
    // ready, so decode simply holds the instruction while stall is high.
    modport master (
        output issue_valid, issue_we, issue_wa, ra1, ra2, wb_valid, wb_wa, flush,
        input  stall, busy1, busy2, pending_total, err
    );

    modport slave (
        input  issue_valid, issue_we, issue_wa, ra1, ra2, wb_valid, wb_wa, flush,
        output stall, busy1, busy2, pending_total, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register outstanding-write counters for the CPU pipeline; raises stall while a source
// register still has a write in flight, with same-cycle bypass of writeback retires.
module reg_scoreboard #(
    parameter int CNT_W = 2,
    parameter int NREG  = 32
) (
    input  logic             clk,
    input  logic             rst,
    reg_scoreboard_if.slave  bus
);
    localparam int               AW  = 5;
    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] r_cnt [1:NREG-1];
    logic [CNT_W-1:0] w_cnt [NREG];
    logic [7:0]       r_pending;
    logic             r_err;

    logic w_hit1, w_hit2, w_hit_wa;
    logic w_busy1, w_busy2, w_full, w_stall, w_acc;
    logic w_same, w_ret_ok, w_ret_bad, w_inc, w_dec;

    // r0 has no counter; it always reads as idle.
    always_comb begin
        w_cnt[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            w_cnt[r] = r_cnt[r];
        end
    end

    assign w_hit1   = bus.wb_valid && (bus.wb_wa == bus.ra1) && (bus.ra1 != '0);
    assign w_hit2   = bus.wb_valid && (bus.wb_wa == bus.ra2) && (bus.ra2 != '0);
    assign w_hit_wa = bus.wb_valid && (bus.wb_wa == bus.issue_wa) && (bus.issue_wa != '0);

    // A retire of the last outstanding write clears busy in the same cycle.
    assign w_busy1 = (bus.ra1 != '0) && (w_cnt[bus.ra1] != '0) &&
                     !(w_hit1 && (w_cnt[bus.ra1] == CNT_W'(1)));
    assign w_busy2 = (bus.ra2 != '0) && (w_cnt[bus.ra2] != '0) &&
                     !(w_hit2 && (w_cnt[bus.ra2] == CNT_W'(1)));
    assign w_full  = bus.issue_we && (bus.issue_wa != '0) &&
                     (w_cnt[bus.issue_wa] == MAX) && !w_hit_wa;

    assign w_stall = bus.issue_valid && !bus.flush && (w_busy1 || w_busy2 || w_full);
    assign w_acc   = bus.issue_valid && !w_stall && !bus.flush && bus.issue_we &&
                     (bus.issue_wa != '0);

    // Issue and retire on the same register cancel: no change, no error.
    assign w_same    = w_acc && w_hit_wa;
    assign w_ret_ok  = bus.wb_valid && (bus.wb_wa != '0) && (w_cnt[bus.wb_wa] != '0);
    assign w_ret_bad = bus.wb_valid && (bus.wb_wa != '0) && (w_cnt[bus.wb_wa] == '0) && !w_same;
    assign w_inc     = w_acc && !w_same;
    assign w_dec     = w_ret_ok && !w_same;

    for (genvar g = 1; g < NREG; g++) begin : g_cnt
        logic w_acc_r, w_ret_r;
        assign w_acc_r = w_acc && (bus.issue_wa == AW'(g));
        assign w_ret_r = bus.wb_valid && (bus.wb_wa == AW'(g));

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_cnt[g] <= '0;
            end else if (bus.flush) begin
                r_cnt[g] <= '0;
            end else if (w_acc_r && !w_ret_r) begin
                r_cnt[g] <= r_cnt[g] + CNT_W'(1);
            end else if (w_ret_r && !w_acc_r && (r_cnt[g] != '0)) begin
                r_cnt[g] <= r_cnt[g] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= '0;
        end else if (bus.flush) begin
            r_pending <= '0;
        end else if (w_inc && !w_dec) begin
            r_pending <= r_pending + 8'd1;
        end else if (w_dec && !w_inc) begin
            r_pending <= r_pending - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (!bus.flush && w_ret_bad) begin
            r_err <= 1'b1;
        end
    end

    assign bus.stall         = w_stall;
    assign bus.busy1         = w_busy1;
    assign bus.busy2         = w_busy2;
    assign bus.pending_total = r_pending;
    assign bus.err           = r_err;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: issue/retire/bypass, full counters, r0, flush, sticky err
// and asynchronous reset.
module tb_reg_scoreboard;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    reg_scoreboard_if sb_if ();

    reg_scoreboard #(.CNT_W(2), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        sb_if.issue_valid = 1'b0;
        sb_if.issue_we    = 1'b0;
        sb_if.issue_wa    = 5'd0;
        sb_if.ra1         = 5'd0;
        sb_if.ra2         = 5'd0;
        sb_if.wb_valid    = 1'b0;
        sb_if.wb_wa       = 5'd0;
        sb_if.flush       = 1'b0;
    endtask

    // Inputs change 1 time unit after the posedge; outputs are checked 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] wa);
        sb_if.issue_valid = 1'b1;
        sb_if.issue_we    = 1'b1;
        sb_if.issue_wa    = wa;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(sb_if.stall), 0);
        check("rst_busy1", 32'(sb_if.busy1), 0);
        check("rst_pending", 32'(sb_if.pending_total), 0);
        check("rst_err", 32'(sb_if.err), 0);
        rst = 1'b1;
        step();

        // Single write to r5, then a dependent reader.
        issue(5'd5);
        #1 check("iss5_stall", 32'(sb_if.stall), 0);
        step();
        sb_if.ra1 = 5'd5;
        #1;
        check("r5_busy1", 32'(sb_if.busy1), 1);
        check("r5_stall", 32'(sb_if.stall), 1);
        check("r5_pending", 32'(sb_if.pending_total), 1);
        step();
        check("r5_held_pending", 32'(sb_if.pending_total), 1);

        // Retire bypass: non-writing reader of r5 proceeds in the retire cycle.
        sb_if.issue_we = 1'b0;
        sb_if.wb_valid = 1'b1;
        sb_if.wb_wa    = 5'd5;
        #1;
        check("byp_busy1", 32'(sb_if.busy1), 0);
        check("byp_stall", 32'(sb_if.stall), 0);
        step();
        idle();
        sb_if.ra1 = 5'd5;
        #1;
        check("byp_pending", 32'(sb_if.pending_total), 0);
        check("byp_busy_after", 32'(sb_if.busy1), 0);
        check("byp_err", 32'(sb_if.err), 0);

        // Three writes to r7 fill its counter.
        idle();
        for (int i = 1; i <= 3; i++) begin
            issue(5'd7);
            step();
            check($sformatf("r7_fill%0d", i), 32'(sb_if.pending_total), 32'(i));
        end
        #1 check("r7_full_stall", 32'(sb_if.stall), 1);
        sb_if.wb_valid = 1'b1;
        sb_if.wb_wa    = 5'd7;
        #1 check("r7_full_retire_stall", 32'(sb_if.stall), 0);
        step();
        idle();
        sb_if.ra2 = 5'd7;
        #1;
        check("r7_swap_pending", 32'(sb_if.pending_total), 3);
        check("r7_busy2", 32'(sb_if.busy2), 1);
        // Drain r7: busy2 stays up until the retire of the last write.
        sb_if.wb_valid = 1'b1;
        sb_if.wb_wa    = 5'd7;
        for (int i = 3; i >= 1; i--) begin
            #1 check($sformatf("r7_drain_busy%0d", i), 32'(sb_if.busy2), (i == 1) ? 0 : 1);
            step();
        end
        idle();
        #1;
        check("r7_drained_pending", 32'(sb_if.pending_total), 0);
        check("r7_drained_err", 32'(sb_if.err), 0);

        // Writes to r0 are never tracked and never stall.
        for (int i = 0; i < 10; i++) begin
            issue(5'd0);
            #1 check($sformatf("r0_stall%0d", i), 32'(sb_if.stall), 0);
            step();
        end
        check("r0_pending", 32'(sb_if.pending_total), 0);
        idle();
        sb_if.wb_valid = 1'b1;
        sb_if.wb_wa    = 5'd0;
        step();
        check("r0_retire_err", 32'(sb_if.err), 0);

        // Issue and retire to an idle register in one cycle cancel out.
        idle();
        issue(5'd15);
        sb_if.wb_valid = 1'b1;
        sb_if.wb_wa    = 5'd15;
        step();
        idle();
        sb_if.ra1 = 5'd15;
        #1;
        check("same_pending", 32'(sb_if.pending_total), 0);
        check("same_busy1", 32'(sb_if.busy1), 0);
        check("same_err", 32'(sb_if.err), 0);

        // cnt[3]=2, cnt[9]=1, then flush with a valid issue to r4 and a stray retire.
        idle();
        issue(5'd3); step();
        issue(5'd3); step();
        issue(5'd9); step();
        idle();
        sb_if.ra1 = 5'd3;
        sb_if.ra2 = 5'd9;
        #1;
        check("pre_flush_pending", 32'(sb_if.pending_total), 3);
        check("pre_flush_busy1", 32'(sb_if.busy1), 1);
        check("pre_flush_busy2", 32'(sb_if.busy2), 1);
        issue(5'd4);
        sb_if.flush    = 1'b1;
        sb_if.wb_valid = 1'b1;
        sb_if.wb_wa    = 5'd20;
        #1 check("flush_stall", 32'(sb_if.stall), 0);
        step();
        idle();
        sb_if.ra1 = 5'd3;
        sb_if.ra2 = 5'd4;
        #1;
        check("post_flush_pending", 32'(sb_if.pending_total), 0);
        check("post_flush_busy1", 32'(sb_if.busy1), 0);
        check("post_flush_busy2_r4", 32'(sb_if.busy2), 0);
        check("post_flush_err", 32'(sb_if.err), 0);
        sb_if.wb_valid = 1'b1;
        sb_if.wb_wa    = 5'd3;
        step();
        idle();
        check("underflow_err", 32'(sb_if.err), 1);
        check("underflow_pending", 32'(sb_if.pending_total), 0);
        repeat (3) step();
        check("err_sticky", 32'(sb_if.err), 1);

        // Asynchronous reset in the middle of a cycle with r12 holding two writes.
        issue(5'd12); step();
        issue(5'd12); step();
        sb_if.ra1 = 5'd12;
        #1;
        check("r12_pending", 32'(sb_if.pending_total), 2);
        check("r12_stall", 32'(sb_if.stall), 1);
        #1 rst = 1'b0;
        #1;
        check("async_busy1", 32'(sb_if.busy1), 0);
        check("async_stall", 32'(sb_if.stall), 0);
        check("async_pending", 32'(sb_if.pending_total), 0);
        check("async_err", 32'(sb_if.err), 0);
        idle();
        step();
        rst = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
